// File: rtl/safecrack_lock_param.sv
// Push-button safe combination lock.
// Compares a CODE_LEN-press sequence against a runtime-programmable code,
// blinks the unlocked LED while open, and enforces a timed lockout after
// MAX_TRIES consecutive wrong entries. Buttons arrive debounced and active-low.
module safecrack_lock_param #(
    parameter int NUM_BTN        = 4,
    parameter int CODE_LEN       = 4,
    parameter logic [CODE_LEN*$clog2(NUM_BTN)-1:0] DEFAULT_CODE = 8'hE4,
    parameter int MAX_TRIES      = 3,
    parameter int BLINK_CYCLES   = 50_000_000,
    parameter int LOCKOUT_CYCLES = 500_000_000,
    parameter int ENTRY_TIMEOUT  = 250_000_000
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NUM_BTN-1:0]                btn,
    input  logic                              prog_en,
    output logic                              unlocked,
    output logic                              locked_out,
    output logic                              prog_active,
    output logic [3:0]                        fail_cnt,
    output logic [$clog2(CODE_LEN+1)-1:0]     digits_entered
);

    localparam int BW  = $clog2(NUM_BTN);
    localparam int IW  = $clog2(CODE_LEN+1);
    localparam int CW  = CODE_LEN*BW;
    localparam int BCW = $clog2(BLINK_CYCLES+1);
    localparam int LCW = $clog2(LOCKOUT_CYCLES+1);
    localparam int TCW = $clog2(ENTRY_TIMEOUT+1);

    typedef enum logic [2:0] {
        S_ENTRY      = 3'd0,
        S_UNLOCK_ON  = 3'd1,
        S_UNLOCK_OFF = 3'd2,
        S_PROGRAM    = 3'd3,
        S_LOCKOUT    = 3'd4
    } state_t;

    state_t           state_q, state_n;
    logic [IW-1:0]    idx_q, idx_n;
    logic             mism_q, mism_n;
    logic [3:0]       fail_q, fail_n;
    logic [BCW-1:0]   blink_q, blink_n;
    logic [LCW-1:0]   lock_q, lock_n;
    logic [TCW-1:0]   idle_q, idle_n;
    logic [CW-1:0]    code_q, code_n;
    logic [CW-1:0]    shadow_q, shadow_n;
    logic [NUM_BTN-1:0] btn_prev;
    logic             armed_q;

    logic [NUM_BTN-1:0] pos;
    logic [NUM_BTN-1:0] btn_edge;
    logic             any_edge;
    logic             valid_press;
    logic             bad_press;
    logic [BW-1:0]    press_digit;
    logic [BW-1:0]    cur_digit;
    logic [CW-1:0]    shadow_wr;
    logic             mism_in;
    logic             last_digit;
    logic             idle_expired;
    logic [3:0]       fail_inc;

    logic             unlocked_n;
    logic             locked_out_n;
    logic             prog_active_n;
    logic [IW-1:0]    digits_n;

    // Press detection: a press is a fresh high on the inverted button level.
    // armed_q masks the very first cycle after reset so that a button held
    // through reset release is loaded into btn_prev instead of seen as a press.
    always_comb begin
        pos         = ~btn;
        btn_edge    = pos & ~btn_prev & {NUM_BTN{armed_q}};
        any_edge    = |btn_edge;
        valid_press = any_edge && ((btn_edge & (btn_edge - 1'b1)) == '0);
        bad_press   = any_edge && !valid_press;
        press_digit = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (btn_edge[i]) begin
                press_digit = BW'(i);
            end
        end
    end

    // Digit selection: current code digit for comparison and the shadow code
    // with the pressed digit written at the current position.
    always_comb begin
        cur_digit = '0;
        shadow_wr = shadow_q;
        for (int k = 0; k < CODE_LEN; k++) begin
            if (idx_q == IW'(k)) begin
                cur_digit                = code_q[k*BW +: BW];
                shadow_wr[k*BW +: BW]    = press_digit;
            end
        end
    end

    // Next-state and counter logic for all five states.
    always_comb begin
        state_n      = state_q;
        idx_n        = idx_q;
        mism_n       = mism_q;
        fail_n       = fail_q;
        blink_n      = blink_q;
        lock_n       = lock_q;
        idle_n       = idle_q;
        code_n       = code_q;
        shadow_n     = shadow_q;
        mism_in      = mism_q || bad_press || (valid_press && (press_digit != cur_digit));
        last_digit   = (idx_q == IW'(CODE_LEN-1));
        idle_expired = (idle_q == TCW'(ENTRY_TIMEOUT-1));
        fail_inc     = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;

        case (state_q)
            S_ENTRY: begin
                if (any_edge) begin
                    idle_n = '0;
                    if (last_digit) begin
                        idx_n  = '0;
                        mism_n = 1'b0;
                        if (!mism_in) begin
                            state_n = S_UNLOCK_ON;
                            fail_n  = 4'd0;
                            blink_n = '0;
                        end else begin
                            fail_n = fail_inc;
                            if (fail_inc == 4'(MAX_TRIES)) begin
                                state_n = S_LOCKOUT;
                                lock_n  = '0;
                            end
                        end
                    end else begin
                        idx_n  = idx_q + IW'(1);
                        mism_n = mism_in;
                    end
                end else if (idx_q != '0) begin
                    if (idle_expired) begin
                        idx_n  = '0;
                        mism_n = 1'b0;
                        idle_n = '0;
                    end else begin
                        idle_n = idle_q + TCW'(1);
                    end
                end
            end

            S_UNLOCK_ON, S_UNLOCK_OFF: begin
                if (any_edge) begin
                    idx_n   = '0;
                    mism_n  = 1'b0;
                    idle_n  = '0;
                    state_n = (valid_press && prog_en) ? S_PROGRAM : S_ENTRY;
                end else if (blink_q == BCW'(BLINK_CYCLES-1)) begin
                    blink_n = '0;
                    state_n = (state_q == S_UNLOCK_ON) ? S_UNLOCK_OFF : S_UNLOCK_ON;
                end else begin
                    blink_n = blink_q + BCW'(1);
                end
            end

            S_PROGRAM: begin
                if (valid_press) begin
                    idle_n   = '0;
                    shadow_n = shadow_wr;
                    if (last_digit) begin
                        code_n  = shadow_wr;
                        state_n = S_ENTRY;
                        idx_n   = '0;
                        fail_n  = 4'd0;
                    end else begin
                        idx_n = idx_q + IW'(1);
                    end
                end else if (bad_press || idle_expired) begin
                    state_n = S_ENTRY;
                    idx_n   = '0;
                    idle_n  = '0;
                end else begin
                    idle_n = idle_q + TCW'(1);
                end
            end

            S_LOCKOUT: begin
                if (lock_q == LCW'(LOCKOUT_CYCLES-1)) begin
                    state_n = S_ENTRY;
                    fail_n  = 4'd0;
                    idx_n   = '0;
                    lock_n  = '0;
                    idle_n  = '0;
                    mism_n  = 1'b0;
                end else begin
                    lock_n = lock_q + LCW'(1);
                end
            end

            default: begin
                state_n = S_ENTRY;
                idx_n   = '0;
                mism_n  = 1'b0;
                idle_n  = '0;
                blink_n = '0;
                lock_n  = '0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs change
    // together with the state they describe.
    always_comb begin
        unlocked_n    = (state_n == S_UNLOCK_ON);
        locked_out_n  = (state_n == S_LOCKOUT);
        prog_active_n = (state_n == S_PROGRAM);
        digits_n      = ((state_n == S_ENTRY) || (state_n == S_PROGRAM)) ? idx_n : '0;
    end

    // State, counters, code storage and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_ENTRY;
            idx_q          <= '0;
            mism_q         <= 1'b0;
            fail_q         <= 4'd0;
            blink_q        <= '0;
            lock_q         <= '0;
            idle_q         <= '0;
            code_q         <= DEFAULT_CODE;
            shadow_q       <= '0;
            btn_prev       <= '0;
            armed_q        <= 1'b0;
            unlocked       <= 1'b0;
            locked_out     <= 1'b0;
            prog_active    <= 1'b0;
            fail_cnt       <= 4'd0;
            digits_entered <= '0;
        end else begin
            state_q        <= state_n;
            idx_q          <= idx_n;
            mism_q         <= mism_n;
            fail_q         <= fail_n;
            blink_q        <= blink_n;
            lock_q         <= lock_n;
            idle_q         <= idle_n;
            code_q         <= code_n;
            shadow_q       <= shadow_n;
            btn_prev       <= pos;
            armed_q        <= 1'b1;
            unlocked       <= unlocked_n;
            locked_out     <= locked_out_n;
            prog_active    <= prog_active_n;
            fail_cnt       <= fail_n;
            digits_entered <= digits_n;
        end
    end

endmodule
